// File: rtl/pump_pkg.sv
// Level-code types, injection modes and the volume quantizer shared by the pump
// controller and the tank plant emulator.
package pump_pkg;

  typedef logic [2:0] lvl_code_t;

  localparam lvl_code_t LVL_0       = 3'd0;
  localparam lvl_code_t LVL_25      = 3'd1;
  localparam lvl_code_t LVL_50      = 3'd2;
  localparam lvl_code_t LVL_75      = 3'd3;
  localparam lvl_code_t LVL_100     = 3'd4;
  localparam lvl_code_t LVL_INVALID = 3'd7;

  typedef enum logic [1:0] {
    INJ_NONE    = 2'b00,
    INJ_INVALID = 2'b01,
    INJ_STUCK   = 2'b10,
    INJ_CHATTER = 2'b11
  } inj_mode_t;

  // cap is a multiple of 4, so the quarter thresholds are exact
  function automatic lvl_code_t vol_to_code(input int unsigned v, input int unsigned cap);
    if (v == cap)                return LVL_100;
    else if (v >= (3 * cap) / 4) return LVL_75;
    else if (v >= cap / 2)       return LVL_50;
    else if (v >= cap / 4)       return LVL_25;
    else                         return LVL_0;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running modulo-TICK_CYC counter; tick is high for the last count of each period.
// First tick appears TICK_CYC-1 clocks after reset release.
module tick_gen #(
  parameter int TICK_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_CYC > 2) ? $clog2(TICK_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/tank_plant_emulator.sv
// Two-tank hydraulic plant: volumes update on the edge ending each tick cycle,
// level codes (with optional fault injection) follow one clock later.
module tank_plant_emulator
  import pump_pkg::*;
#(
  parameter  int CLK_HZ     = 25_000_000,
  parameter  int TICK_MS    = 100,
  parameter  int CAP_UNITS  = 400,
  parameter  int PUMP_RATE  = 5,
  parameter  int FILL_RATE  = 4,
  parameter  int DRAIN_RATE = 2,
  parameter  int INIT_INF   = 300,
  parameter  int INIT_SUP   = 100,
  localparam int VOL_W      = $clog2(CAP_UNITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pump_on,
  input  logic             solenoid_open,
  input  logic             drain_en,
  input  logic             freeze,
  input  logic [1:0]       inj_mode,
  output logic [2:0]       lvl_inf_code,
  output logic [2:0]       lvl_sup_code,
  output logic [VOL_W-1:0] vol_inf,
  output logic [VOL_W-1:0] vol_sup,
  output logic             tick,
  output logic             overflow_sup,
  output logic             dry_inf
);

  localparam int TICK_CYC = (CLK_HZ / 1000) * TICK_MS;

  typedef logic [VOL_W:0] ext_t;

  localparam ext_t CAP_E   = ext_t'(CAP_UNITS);
  localparam ext_t PUMP_E  = ext_t'(PUMP_RATE);
  localparam ext_t FILL_E  = ext_t'(FILL_RATE);
  localparam ext_t DRAIN_E = ext_t'(DRAIN_RATE);

  localparam lvl_code_t INIT_INF_CODE = vol_to_code(INIT_INF, CAP_UNITS);
  localparam lvl_code_t INIT_SUP_CODE = vol_to_code(INIT_SUP, CAP_UNITS);

  tick_gen #(.TICK_CYC(TICK_CYC)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  ext_t             xfer, fill, inf_sum, sup_sum, sup_clamp, sup_fin;
  logic [VOL_W-1:0] inf_nxt, sup_nxt;
  logic             spill, starve;

  // One combined update: pump transfer, refill, spill clamp, then drain.
  always_comb begin
    xfer = '0;
    if (pump_on) xfer = (ext_t'(vol_inf) < PUMP_E) ? ext_t'(vol_inf) : PUMP_E;
    fill      = solenoid_open ? FILL_E : '0;
    inf_sum   = ext_t'(vol_inf) - xfer + fill;
    inf_nxt   = (inf_sum > CAP_E) ? CAP_E[VOL_W-1:0] : inf_sum[VOL_W-1:0];
    sup_sum   = ext_t'(vol_sup) + xfer;
    spill     = (sup_sum > CAP_E);
    sup_clamp = spill ? CAP_E : sup_sum;
    sup_fin   = sup_clamp;
    if (drain_en) sup_fin = (sup_clamp >= DRAIN_E) ? sup_clamp - DRAIN_E : '0;
    sup_nxt   = sup_fin[VOL_W-1:0];
    starve    = pump_on && (ext_t'(vol_inf) < PUMP_E);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vol_inf      <= VOL_W'(INIT_INF);
      vol_sup      <= VOL_W'(INIT_SUP);
      overflow_sup <= 1'b0;
      dry_inf      <= 1'b0;
    end else begin
      overflow_sup <= 1'b0;
      dry_inf      <= 1'b0;
      if (tick && !freeze) begin
        vol_inf      <= inf_nxt;
        vol_sup      <= sup_nxt;
        overflow_sup <= spill;
        dry_inf      <= starve;
      end
    end
  end

  inj_mode_t mode;
  lvl_code_t true_inf, true_sup, inf_code_nxt, sup_code_nxt;
  logic      chat_ph;

  assign mode     = inj_mode_t'(inj_mode);
  assign true_inf = vol_to_code(32'(vol_inf), CAP_UNITS);
  assign true_sup = vol_to_code(32'(vol_sup), CAP_UNITS);

  // Stuck mode simply stops reloading the sup code register.
  always_comb begin
    inf_code_nxt = true_inf;
    sup_code_nxt = true_sup;
    case (mode)
      INJ_INVALID: inf_code_nxt = LVL_INVALID;
      INJ_CHATTER: inf_code_nxt = chat_ph ? (true_inf ^ 3'b001) : true_inf;
      INJ_STUCK:   sup_code_nxt = lvl_sup_code;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_inf_code <= INIT_INF_CODE;
      lvl_sup_code <= INIT_SUP_CODE;
      chat_ph      <= 1'b0;
    end else begin
      lvl_inf_code <= inf_code_nxt;
      lvl_sup_code <= sup_code_nxt;
      chat_ph      <= (mode == INJ_CHATTER) ? ~chat_ph : 1'b0;
    end
  end

endmodule

// File: tb/tb_tank_plant_emulator.sv
// Scoreboard bench: stimulus queues cycle-tagged expectations, a negedge monitor checks them.
module tb_tank_plant_emulator;

  localparam int VI = 0, VS = 1, CI = 2, CS = 3, TK = 4, OV = 5, DR = 6;

  typedef struct {
    int tag;
    int dut;
    int sig;
    int val;
  } exp_t;

  exp_t sb[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       pump[4], sol[4], drn[4], frz[4];
  logic [1:0] inj[4];
  logic [2:0] ci[4], cs[4];
  logic [8:0] vi[4], vs[4];
  logic       tk[4], ov[4], dr[4];

  int now   = 0;
  int r0    = 0;
  int total = 0;
  int bad   = 0;

  int init_vi[4] = '{300, 300, 3, 300};
  int init_vs[4] = '{100, 398, 100, 100};
  int init_ci[4] = '{3, 3, 0, 3};
  int init_cs[4] = '{1, 3, 1, 1};

  initial forever #5 clk = ~clk;
  always @(posedge clk) now <= now + 1;

  tank_plant_emulator #(.CLK_HZ(1000), .TICK_MS(4)) dut0 (
    .clk(clk), .rst(rst), .pump_on(pump[0]), .solenoid_open(sol[0]), .drain_en(drn[0]),
    .freeze(frz[0]), .inj_mode(inj[0]), .lvl_inf_code(ci[0]), .lvl_sup_code(cs[0]),
    .vol_inf(vi[0]), .vol_sup(vs[0]), .tick(tk[0]), .overflow_sup(ov[0]), .dry_inf(dr[0]));

  tank_plant_emulator #(.CLK_HZ(1000), .TICK_MS(4), .INIT_SUP(398)) dut1 (
    .clk(clk), .rst(rst), .pump_on(pump[1]), .solenoid_open(sol[1]), .drain_en(drn[1]),
    .freeze(frz[1]), .inj_mode(inj[1]), .lvl_inf_code(ci[1]), .lvl_sup_code(cs[1]),
    .vol_inf(vi[1]), .vol_sup(vs[1]), .tick(tk[1]), .overflow_sup(ov[1]), .dry_inf(dr[1]));

  tank_plant_emulator #(.CLK_HZ(1000), .TICK_MS(4), .INIT_INF(3)) dut2 (
    .clk(clk), .rst(rst), .pump_on(pump[2]), .solenoid_open(sol[2]), .drain_en(drn[2]),
    .freeze(frz[2]), .inj_mode(inj[2]), .lvl_inf_code(ci[2]), .lvl_sup_code(cs[2]),
    .vol_inf(vi[2]), .vol_sup(vs[2]), .tick(tk[2]), .overflow_sup(ov[2]), .dry_inf(dr[2]));

  tank_plant_emulator #(.CLK_HZ(1000), .TICK_MS(4)) dut3 (
    .clk(clk), .rst(rst), .pump_on(pump[3]), .solenoid_open(sol[3]), .drain_en(drn[3]),
    .freeze(frz[3]), .inj_mode(inj[3]), .lvl_inf_code(ci[3]), .lvl_sup_code(cs[3]),
    .vol_inf(vi[3]), .vol_sup(vs[3]), .tick(tk[3]), .overflow_sup(ov[3]), .dry_inf(dr[3]));

  function automatic int sample(int d, int s);
    case (s)
      VI:      return int'(vi[d]);
      VS:      return int'(vs[d]);
      CI:      return int'(ci[d]);
      CS:      return int'(cs[d]);
      TK:      return int'(tk[d]);
      OV:      return int'(ov[d]);
      default: return int'(dr[d]);
    endcase
  endfunction

  function automatic string sname(int s);
    case (s)
      VI:      return "vol_inf";
      VS:      return "vol_sup";
      CI:      return "lvl_inf_code";
      CS:      return "lvl_sup_code";
      TK:      return "tick";
      OV:      return "overflow_sup";
      default: return "dry_inf";
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle; an entry whose cycle passed is a miss.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tag == now) begin
        total++;
        if (sample(sb[i].dut, sb[i].sig) != sb[i].val) begin
          bad++;
          $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", sname(sb[i].sig), sb[i].dut,
                   now - r0, sample(sb[i].dut, sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].tag < now) begin
        total++;
        bad++;
        $display("FAIL %s dut%0d missed check at cyc=%0d", sname(sb[i].sig), sb[i].dut,
                 sb[i].tag - r0);
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rel(input int dly, input int d, input int s, input int v);
    sb.push_back('{now + dly, d, s, v});
  endtask

  task automatic exp_at(input int t, input int d, input int s, input int v);
    sb.push_back('{r0 + t, d, s, v});
  endtask

  task automatic go(input int t);
    while (now < r0 + t) step();
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      pump[d] = 0; sol[d] = 0; drn[d] = 0; frz[d] = 0; inj[d] = 2'b00;
    end
    rst = 1'b1;
    step();
    for (int d = 0; d < 4; d++) begin
      exp_rel(0, d, VI, init_vi[d]);
      exp_rel(0, d, VS, init_vs[d]);
      exp_rel(0, d, CI, init_ci[d]);
      exp_rel(0, d, CS, init_cs[d]);
      exp_rel(0, d, TK, 0);
      exp_rel(0, d, OV, 0);
      exp_rel(0, d, DR, 0);
    end
    step();
    rst = 1'b0;
    exp_rel(0, 0, TK, 0);
    exp_rel(1, 0, TK, 0);
    exp_rel(2, 0, TK, 0);
    step();
    step();
    // mid-period reset: count is 2 here and must drop back to 0
    rst = 1'b1;
    exp_rel(0, 0, TK, 0);
    exp_rel(0, 0, VI, 300);
    step();
    rst = 1'b0;
    r0 = now;

    // restarted count: first tick 3 clocks after release
    exp_at(0, 0, TK, 0); exp_at(2, 0, TK, 0); exp_at(3, 0, TK, 1); exp_at(4, 0, TK, 0);
    exp_at(7, 0, TK, 1);

    // dut0 pumping for 20 ticks
    exp_at(4, 0, VI, 295);  exp_at(4, 0, VS, 105);
    exp_at(4, 0, CI, 3);    exp_at(5, 0, CI, 2);
    exp_at(79, 0, VS, 195);
    exp_at(80, 0, VI, 200); exp_at(80, 0, VS, 200); exp_at(80, 0, CS, 1);
    exp_at(81, 0, CS, 2);   exp_at(81, 0, CI, 2);
    exp_at(84, 0, VI, 200); exp_at(84, 0, VS, 200);

    // dut1 overflow, then overflow with drain
    exp_at(3, 1, OV, 0);
    exp_at(4, 1, VS, 400);  exp_at(4, 1, VI, 295); exp_at(4, 1, OV, 1);
    exp_at(5, 1, OV, 0);    exp_at(5, 1, CS, 4);
    exp_at(8, 1, VS, 398);  exp_at(8, 1, VI, 290); exp_at(8, 1, OV, 1);
    exp_at(12, 1, VS, 398); exp_at(12, 1, OV, 0);

    // dut2 dry run, then refill to the cap and beyond
    exp_at(4, 2, VI, 0);    exp_at(4, 2, VS, 103); exp_at(4, 2, DR, 1);
    exp_at(5, 2, DR, 0);    exp_at(5, 2, CI, 0);   exp_at(8, 2, DR, 0);
    exp_at(8, 2, VI, 4);    exp_at(400, 2, VI, 396);
    exp_at(404, 2, VI, 400); exp_at(404, 2, CI, 3); exp_at(405, 2, CI, 4);
    exp_at(412, 2, VI, 400);

    // dut3 injection modes, then freeze
    exp_at(1, 3, CI, 3);    exp_at(2, 3, CI, 7);
    exp_at(3, 3, CI, 3);    exp_at(4, 3, CI, 2);   exp_at(5, 3, CI, 3); exp_at(6, 3, CI, 2);
    exp_at(7, 3, CI, 3);
    exp_at(9, 3, CS, 1);    exp_at(48, 3, VS, 150); exp_at(48, 3, CS, 1);
    exp_at(88, 3, VS, 200); exp_at(89, 3, CS, 1);
    exp_at(91, 3, CS, 2);   exp_at(91, 3, CI, 2);  exp_at(91, 3, VI, 200);
    exp_at(96, 3, OV, 0);   exp_at(100, 3, DR, 0);
    exp_at(111, 3, TK, 1);  exp_at(112, 3, TK, 0);
    exp_at(112, 3, VI, 200); exp_at(112, 3, VS, 200);

    pump[0] = 1; pump[1] = 1; pump[2] = 1;
    go(1);   inj[3] = 2'b01;
    go(2);   inj[3] = 2'b11;
    go(5);   drn[1] = 1; pump[2] = 0; sol[2] = 1;
    go(6);   inj[3] = 2'b00;
    go(8);   inj[3] = 2'b10; pump[3] = 1;
    go(9);   pump[1] = 0; drn[1] = 0;
    go(81);  pump[0] = 0;
    go(89);  pump[3] = 0;
    go(90);  inj[3] = 2'b00;
    go(92);  frz[3] = 1; pump[3] = 1; sol[3] = 1; drn[3] = 1;
    go(113); frz[3] = 0; pump[3] = 0; sol[3] = 0; drn[3] = 0;
    go(413); sol[2] = 0;

    for (int k = 0; k < 50 && sb.size() > 0; k++) step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tank_plant_emulator.md
# tank_plant_emulator

Cycle-based hydraulic model of the two-tank system (lower reservoir "inf", upper tank "sup") that closes the loop around the pump controller on the FPGA demo board. It consumes the controller's `pump_on` / `solenoid_open` outputs and produces the 3-bit level codes (0..4 = 0/25/50/75/100 %) the controller reads as sensor inputs. Fault-injection modes (invalid code, stuck code, chatter) exercise the controller's debounce and fault paths in simulation and on hardware.

## Interface
- `CLK_HZ`, 25_000_000, clock frequency
- `TICK_MS`, 100, plant update period; `TICK_CYC = (CLK_HZ/1000)*TICK_MS`, must be ≥ 2
- `CAP_UNITS`, 400, capacity of each tank in volume units; must be a multiple of 4
- `PUMP_RATE`, 5, units moved inf→sup per tick while pumping
- `FILL_RATE`, 4, units added to inf per tick while the solenoid is open
- `DRAIN_RATE`, 2, units removed from sup per tick while `drain_en`
- `INIT_INF`, 300, inf volume at reset (≤ CAP_UNITS)
- `INIT_SUP`, 100, sup volume at reset (≤ CAP_UNITS)
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `pump_on`  in  1  pump running
- `solenoid_open`  in  1  refill valve open
- `drain_en`  in  1  consumer draw from sup
- `freeze`  in  1  hold volumes; tick counter keeps running
- `inj_mode`  in  2  00 normal, 01 invalid inf code, 10 sup code stuck, 11 inf code chatter
- `lvl_inf_code`  out  3  lower reservoir level code
- `lvl_sup_code`  out  3  upper tank level code
- `vol_inf`  out  VOL_W  inf volume, `VOL_W = $clog2(CAP_UNITS+1)`
- `vol_sup`  out  VOL_W  sup volume
- `tick`  out  1  one-cycle update strobe
- `overflow_sup`  out  1  one-cycle pulse: sup spilled
- `dry_inf`  out  1  one-cycle pulse: pump starved

## Operation
- Tick counter runs 0..TICK_CYC-1 and wraps. `tick` = 1 when the count is TICK_CYC-1.
- On a tick with `freeze`=0, all terms use pre-tick volumes and current inputs:
  - `xfer = pump_on ? min(PUMP_RATE, vol_inf) : 0`
  - `fill = solenoid_open ? FILL_RATE : 0`
  - `vol_inf' = min(CAP, vol_inf - xfer + fill)`. Excess fill is discarded silently.
  - `s = vol_sup + xfer` (VOL_W+1 bits). `overflow_sup` pulses if `s > CAP`; clamp `s` to CAP. Spilled water is lost.
  - `vol_sup' = drain_en ? sat0(s - DRAIN_RATE) : s`
  - `dry_inf` pulses if `pump_on` and `vol_inf < PUMP_RATE`.
- On a tick with `freeze`=1, volumes and flags are unchanged and no pulses are produced.
- Quantizer: `code = 4` if `v == CAP`, `3` if `v ≥ 3CAP/4`, `2` if `v ≥ CAP/2`, `1` if `v ≥ CAP/4`, else `0`.
- Injection is applied after the quantizer and is registered:
  - 01: `lvl_inf_code = 3'd7`
  - 10: `lvl_sup_code` holds the value it had when the mode was entered
  - 11: `lvl_inf_code` alternates each clock between the true code and `true ^ 3'b001`, starting with the true code
  - Returning to 00 restores true codes on the next clock.
- Injection never alters volumes or flags.

## Timing
- Reset values:
  - tick counter 0
  - `vol_inf` = INIT_INF, `vol_sup` = INIT_SUP
  - codes = quantized INIT values
  - `tick`, `overflow_sup`, `dry_inf` = 0
  - chatter phase 0, stuck register = quantized INIT_SUP
- Reset may assert at any cycle, including mid-tick or mid-injection, and returns the block to these values immediately.
- First `tick` occurs TICK_CYC-1 clocks after reset release.
- Volumes and pulses register on the clock edge that ends the `tick` cycle (latency 1).
- Codes update one edge later (latency 2 from `tick`).
- Inputs are sampled only in the `tick` cycle. Between ticks they are don't-care for volumes; `inj_mode` is sampled every clock.
- Simultaneous pump, fill and drain are resolved in a single update in the order given above. An overflow and a drain in the same tick still pulse `overflow_sup`.

## Structure
- Shared package `pump_pkg`:
  - `lvl_code_t` (logic [2:0])
  - constants `LVL_0..LVL_100`, `LVL_INVALID = 3'd7`
  - enum `inj_mode_t`
  - function `vol_to_code`
- Sub-module `tick_gen` (parameter TICK_CYC; ports clk, rst, tick). The rest, including volume datapath, quantizer and injection mux, stays in one file.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_MS=4 (tick every 4 clocks), CAP=400, defaults otherwise.
- **Reset:** assert `rst` → `vol_inf`=300 (code 3), `vol_sup`=100 (code 1), all flags 0; first `tick` at clock 3; asserting `rst` at clock 2 restarts the count.
- **Pumping:** `pump_on`=1 for 20 ticks → `vol_inf`=200, `vol_sup`=200, both codes 2, codes lag `tick` by 2 clocks.
- **Overflow:** INIT_SUP=398, `pump_on` → `vol_sup`=400 (code 4), `vol_inf`=295, `overflow_sup` single pulse; with `drain_en` also set, `vol_sup`=398 and the pulse is still present.
- **Dry run and refill:**
  - INIT_INF=3, `pump_on` → `vol_inf`=0 (code 0), `vol_sup`=103, `dry_inf` pulse.
  - `solenoid_open` for 100 ticks → `vol_inf`=400 (code 4), then clamped.
- **Injection:**
  - 01 → `lvl_inf_code`=7 next clock.
  - 11 → codes 3,2,3,2 at INIT.
  - 10 with pumping → `lvl_sup_code` stays 1 while `vol_sup` reaches 150.
  - 00 → true codes on the next clock.
- **Freeze:** `freeze`=1 with all inputs active for 5 ticks → volumes unchanged, no pulses, `tick` still toggles.
